mastermind_engine: RTL and testbench
====================================

// Module: mastermind_engine
// PURPOSE
//  Parametrised Mastermind game core: holds the secret code and accepts guesses over a valid/ready handshake.
//  Scores each guess sequentially as exact and partial peg counts, and stores every scored guess in a history buffer.
//  Tracks turns and declares WON or LOST. Sits between the guess-entry/debounce front end and the LED/SSD display drivers.
//  Generalises the fixed 4-peg, 8-colour design to any peg count, colour count and turn limit.
// PARAMETERS
//  PEGS       4   pegs per code
//  COLORS     8   legal colours 0..COLORS-1 (>=2)
//  MAX_TURNS  8   guesses allowed before LOST
//  derived: CW=$clog2(COLORS), TW=$clog2(MAX_TURNS+1), PW=$clog2(PEGS+1)
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        async active-low reset
//  start         in   1        1-cycle pulse: latch secret, clear history, enter PLAY
//  secret        in   PEGS*CW  code to be guessed; peg i at [i*CW +: CW]
//  guess_valid   in   1        guess offered
//  guess_ready   out  1        high only in PLAY
//  guess         in   PEGS*CW  guess pegs, same packing as secret
//  score_valid   out  1        1-cycle pulse: exact/partial hold the new score
//  exact         out  PW       pegs with correct colour and position
//  partial       out  PW       pegs with correct colour, wrong position
//  bad_guess     out  1        1-cycle pulse: guess rejected (a peg >= COLORS)
//  turn          out  TW       number of scored guesses this game
//  state         out  2        0 IDLE, 1 PLAY, 2 WON, 3 LOST (SCORE reports as PLAY)
//  hist_idx      in   TW       history entry to read
//  hist_guess    out  PEGS*CW  stored guess at hist_idx (registered, 1-cycle latency)
//  hist_exact    out  PW       stored exact count at hist_idx
//  hist_partial  out  PW       stored partial count at hist_idx
// BEHAVIOUR
//  Reset: state IDLE; turn, exact, partial, hist_* = 0; score_valid, bad_guess, guess_ready = 0; history cleared.
//  FSM: IDLE -start-> PLAY -accept-> SCORE (COLORS cycles) -> FINISH (1 cycle) -> PLAY | WON | LOST.
//       WON/LOST -start-> PLAY. IDLE/WON/LOST ignore guess_valid.
//  Accept = guess_valid & guess_ready on a clk edge. The guess is latched and guess_ready drops the next cycle.
//  Out-of-range peg in accepted guess: pulse bad_guess the next cycle, stay in PLAY, turn unchanged, no history write.
//  SCORE: exact = count(g[i]==s[i]), computed on the entry cycle. Cycle c (0..COLORS-1) adds
//    min(#g==c, #s==c) to a PW+1-bit accumulator. In FINISH, partial = acc - exact.
//  FINISH: write {guess,exact,partial} to history[turn]; turn+1; score_valid pulses for that cycle.
//    exact/partial outputs then hold until the next score or start.
//  score_valid therefore rises COLORS+1 cycles after the accept edge.
//  Next state from FINISH: exact==PEGS -> WON (takes priority, even on the final turn);
//    else turn+1==MAX_TURNS -> LOST; else PLAY.
//  start in any state, including mid-SCORE: aborts any scoring with no score_valid and no history write.
//    Re-latches secret; turn, exact and partial go to 0; history valid count resets.
//    Next state is PLAY. start wins over a simultaneous guess_valid.
//  Secret with a peg >= COLORS: start is ignored and the state is unchanged.
//  History read: hist_* is registered from history[hist_idx].
//    hist_idx >= turn or hist_idx >= MAX_TURNS returns all zeros. A read of the entry being written in FINISH
//    returns the new data on the following cycle (write-first).
//  turn saturates at MAX_TURNS; no wrap.
// STRUCTURE
//  mastermind_pkg: state encoding localparams (ST_IDLE..ST_LOST, internal ST_SCORE/ST_FINISH),
//    width helper functions, a peg-extract function.
//  Sub-module mm_scorer: sequential exact/partial counter with start/done.
//    The engine holds the FSM, secret register, history array and read port.
//  History is a register array of MAX_TURNS entries (PEGS*CW+2*PW bits each); no vendor RAM.
// TESTING  (PEGS=4, COLORS=6, MAX_TURNS=10)
//  secret 1,2,3,4; guess 4,3,2,1 -> score_valid 7 cycles after accept, exact 0, partial 4, turn 1.
//  secret 1,1,2,2; guess 1,2,1,1 -> exact 1, partial 2; hist_idx 0 next cycle returns same guess/score.
//  secret 5,0,5,0; guess 5,0,5,0 on turn 1 -> exact 4, state WON, guess_ready 0, further guesses ignored.
//  9 wrong guesses then correct on 10th -> WON; 10 wrong guesses -> LOST with turn 10.
//  guess 1,7,0,0 -> bad_guess pulse, turn unchanged; start pulsed 3 cycles into SCORE -> no score_valid, turn 0, PLAY.
//  rst_n dropped mid-SCORE -> all outputs 0 and IDLE immediately; hist_idx 0 then reads zeros.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared encodings and helpers for the Mastermind engine and its scorer.
package mastermind_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PLAY   = 3'd1;
    localparam logic [2:0] ST_WON    = 3'd2;
    localparam logic [2:0] ST_LOST   = 3'd3;
    localparam logic [2:0] ST_SCORE  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Codes are passed zero-extended to 64 bits so one helper serves every parameterisation.
    function automatic logic [7:0] peg_at(input logic [63:0] code, input int idx, input int cw);
        return 8'(code >> (idx * cw)) & ~(8'hFF << cw);
    endfunction

    function automatic logic [1:0] report_state(input logic [2:0] st);
        case (st)
            ST_IDLE: return 2'd0;
            ST_WON:  return 2'd2;
            ST_LOST: return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/mastermind_engine_scorer.sv
// Sequential scorer: exact matches plus one colour per cycle of min(#guess, #secret) accumulation.
module mm_scorer
    import mastermind_pkg::*;
#(
    parameter  int PEGS   = 4,
    parameter  int COLORS = 8,
    localparam int CW     = width_of(COLORS),
    localparam int PW     = count_w(PEGS),
    localparam int GW     = PEGS * CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [GW-1:0] guess,
    input  logic [GW-1:0] secret,
    output logic          last,
    output logic [PW-1:0] exact,
    output logic [PW:0]   acc
);

    localparam logic [CW-1:0] LAST_C = CW'(COLORS - 1);

    logic          busy_q, busy_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW:0]   acc_q, acc_d;
    logic [PW-1:0] exact_q, exact_d;
    logic [PW-1:0] exact_s, g_cnt_s, s_cnt_s, min_s;

    // Exact matches and occurrences of the colour currently under test
    always_comb begin
        exact_s = {PW{1'b0}};
        g_cnt_s = {PW{1'b0}};
        s_cnt_s = {PW{1'b0}};
        for (int i = 0; i < PEGS; i++) begin
            exact_s = exact_s + PW'(peg_at(64'(guess), i, CW) == peg_at(64'(secret), i, CW));
            g_cnt_s = g_cnt_s + PW'(peg_at(64'(guess), i, CW) == 8'(col_q));
            s_cnt_s = s_cnt_s + PW'(peg_at(64'(secret), i, CW) == 8'(col_q));
        end
        min_s = (g_cnt_s < s_cnt_s) ? g_cnt_s : s_cnt_s;
    end

    // Colour sweep sequencing
    always_comb begin
        busy_d  = busy_q;
        col_d   = col_q;
        acc_d   = acc_q;
        exact_d = exact_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            col_d  = {CW{1'b0}};
            acc_d  = {(PW+1){1'b0}};
        end else if (busy_q) begin
            acc_d   = acc_q + {1'b0, min_s};
            exact_d = exact_s;
            if (col_q == LAST_C) begin
                busy_d = 1'b0;
            end else begin
                col_d = col_q + CW'(1'b1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Scorer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            col_q   <= {CW{1'b0}};
            acc_q   <= {(PW+1){1'b0}};
            exact_q <= {PW{1'b0}};
        end else begin
            busy_q  <= busy_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            exact_q <= exact_d;
        end
    end

    assign last  = busy_q & (col_q == LAST_C);
    assign exact = exact_q;
    assign acc   = acc_q;

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game core: secret latch, guess handshake, turn FSM and write-first history read port.
module mastermind_engine
    import mastermind_pkg::*;
#(
    parameter  int PEGS      = 4,
    parameter  int COLORS    = 8,
    parameter  int MAX_TURNS = 8,
    localparam int CW        = width_of(COLORS),
    localparam int TW        = count_w(MAX_TURNS),
    localparam int PW        = count_w(PEGS),
    localparam int GW        = PEGS * CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [GW-1:0] secret,
    input  logic          guess_valid,
    output logic          guess_ready,
    input  logic [GW-1:0] guess,
    output logic          score_valid,
    output logic [PW-1:0] exact,
    output logic [PW-1:0] partial,
    output logic          bad_guess,
    output logic [TW-1:0] turn,
    output logic [1:0]    state,
    input  logic [TW-1:0] hist_idx,
    output logic [GW-1:0] hist_guess,
    output logic [PW-1:0] hist_exact,
    output logic [PW-1:0] hist_partial
);

    localparam int            IW        = width_of(MAX_TURNS);
    localparam logic [TW-1:0] MAX_T     = TW'(MAX_TURNS);
    localparam logic [PW-1:0] ALL_EXACT = PW'(PEGS);

    logic [2:0]    state_q, state_d;
    logic [1:0]    state_out_q;
    logic          ready_q;
    logic [GW-1:0] secret_q, secret_d, guess_q, guess_d;
    logic [TW-1:0] turn_q, turn_d, turn_inc_s;
    logic [PW-1:0] exact_q, exact_d, partial_q, partial_d;
    logic          score_valid_q, score_valid_d, bad_guess_q, bad_guess_d;
    logic [GW-1:0] hg_q [MAX_TURNS];
    logic [GW-1:0] hg_d [MAX_TURNS];
    logic [PW-1:0] he_q [MAX_TURNS];
    logic [PW-1:0] he_d [MAX_TURNS];
    logic [PW-1:0] hp_q [MAX_TURNS];
    logic [PW-1:0] hp_d [MAX_TURNS];
    logic [GW-1:0] hist_guess_q, hist_guess_d;
    logic [PW-1:0] hist_exact_q, hist_exact_d, hist_partial_q, hist_partial_d;
    logic          secret_ok_s, guess_ok_s, start_ok_s, accept_s, sc_start_s, sc_last_s;
    logic [PW-1:0] sc_exact_s, fin_partial_s;
    logic [PW:0]   sc_acc_s;
    logic [IW-1:0] wr_idx_s, rd_idx_s;

    mm_scorer #(.PEGS(PEGS), .COLORS(COLORS)) u_scorer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (sc_start_s),
        .abort  (start_ok_s),
        .guess  (guess_q),
        .secret (secret_q),
        .last   (sc_last_s),
        .exact  (sc_exact_s),
        .acc    (sc_acc_s)
    );

    // Colour range checks on the raw secret and guess inputs
    always_comb begin
        secret_ok_s = 1'b1;
        guess_ok_s  = 1'b1;
        for (int i = 0; i < PEGS; i++) begin
            secret_ok_s = secret_ok_s & (int'(peg_at(64'(secret), i, CW)) < COLORS);
            guess_ok_s  = guess_ok_s  & (int'(peg_at(64'(guess), i, CW)) < COLORS);
        end
    end

    assign start_ok_s    = start & secret_ok_s;
    assign accept_s      = guess_valid & ready_q & ~start_ok_s;
    assign sc_start_s    = accept_s & guess_ok_s;
    assign fin_partial_s = PW'(sc_acc_s - {1'b0, sc_exact_s});
    assign turn_inc_s    = (turn_q == MAX_T) ? turn_q : turn_q + TW'(1'b1);
    assign wr_idx_s      = IW'(turn_q);
    assign rd_idx_s      = IW'(hist_idx);

    // Game FSM; a valid start overrides everything, including an in-flight score
    always_comb begin
        state_d       = state_q;
        secret_d      = secret_q;
        guess_d       = guess_q;
        turn_d        = turn_q;
        exact_d       = exact_q;
        partial_d     = partial_q;
        score_valid_d = 1'b0;
        bad_guess_d   = 1'b0;
        hg_d          = hg_q;
        he_d          = he_q;
        hp_d          = hp_q;
        if (start_ok_s) begin
            state_d   = ST_PLAY;
            secret_d  = secret;
            turn_d    = {TW{1'b0}};
            exact_d   = {PW{1'b0}};
            partial_d = {PW{1'b0}};
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (accept_s) begin
                        guess_d = guess;
                        if (guess_ok_s) begin
                            state_d = ST_SCORE;
                        end else begin
                            bad_guess_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_SCORE: state_d = sc_last_s ? ST_FINISH : ST_SCORE;
                ST_FINISH: begin
                    hg_d[wr_idx_s] = guess_q;
                    he_d[wr_idx_s] = sc_exact_s;
                    hp_d[wr_idx_s] = fin_partial_s;
                    turn_d         = turn_inc_s;
                    exact_d        = sc_exact_s;
                    partial_d      = fin_partial_s;
                    score_valid_d  = 1'b1;
                    if (sc_exact_s == ALL_EXACT) begin
                        state_d = ST_WON;
                    end else if (turn_inc_s == MAX_T) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // History read sees this cycle's write and the post-update turn count
    always_comb begin
        if ((hist_idx < turn_d) && (hist_idx < MAX_T)) begin
            hist_guess_d   = hg_d[rd_idx_s];
            hist_exact_d   = he_d[rd_idx_s];
            hist_partial_d = hp_d[rd_idx_s];
        end else begin
            hist_guess_d   = {GW{1'b0}};
            hist_exact_d   = {PW{1'b0}};
            hist_partial_d = {PW{1'b0}};
        end
    end

    // Engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            state_out_q    <= 2'd0;
            ready_q        <= 1'b0;
            secret_q       <= {GW{1'b0}};
            guess_q        <= {GW{1'b0}};
            turn_q         <= {TW{1'b0}};
            exact_q        <= {PW{1'b0}};
            partial_q      <= {PW{1'b0}};
            score_valid_q  <= 1'b0;
            bad_guess_q    <= 1'b0;
            hist_guess_q   <= {GW{1'b0}};
            hist_exact_q   <= {PW{1'b0}};
            hist_partial_q <= {PW{1'b0}};
            for (int i = 0; i < MAX_TURNS; i++) begin
                hg_q[i] <= {GW{1'b0}};
                he_q[i] <= {PW{1'b0}};
                hp_q[i] <= {PW{1'b0}};
            end
        end else begin
            state_q        <= state_d;
            state_out_q    <= report_state(state_d);
            ready_q        <= (state_d == ST_PLAY);
            secret_q       <= secret_d;
            guess_q        <= guess_d;
            turn_q         <= turn_d;
            exact_q        <= exact_d;
            partial_q      <= partial_d;
            score_valid_q  <= score_valid_d;
            bad_guess_q    <= bad_guess_d;
            hist_guess_q   <= hist_guess_d;
            hist_exact_q   <= hist_exact_d;
            hist_partial_q <= hist_partial_d;
            hg_q           <= hg_d;
            he_q           <= he_d;
            hp_q           <= hp_d;
        end
    end

    assign guess_ready  = ready_q;
    assign score_valid  = score_valid_q;
    assign exact        = exact_q;
    assign partial      = partial_q;
    assign bad_guess    = bad_guess_q;
    assign turn         = turn_q;
    assign state        = state_out_q;
    assign hist_guess   = hist_guess_q;
    assign hist_exact   = hist_exact_q;
    assign hist_partial = hist_partial_q;

endmodule

// File: tb/tb_mastermind_engine.sv
// Self-checking bench for mastermind_engine against a colour-count reference model.
module tb_mastermind_engine;

    localparam int PEGS = 4;
    localparam int COLORS = 6;
    localparam int MAX_TURNS = 10;
    localparam int GW = 12;
    localparam int TW = 4;
    localparam int PW = 3;
    localparam int LAT = COLORS + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [GW-1:0] secret;
    logic          guess_valid;
    logic          guess_ready;
    logic [GW-1:0] guess;
    logic          score_valid;
    logic [PW-1:0] exact;
    logic [PW-1:0] partial;
    logic          bad_guess;
    logic [TW-1:0] turn;
    logic [1:0]    state;
    logic [TW-1:0] hist_idx;
    logic [GW-1:0] hist_guess;
    logic [PW-1:0] hist_exact;
    logic [PW-1:0] hist_partial;

    int checks = 0;
    int errors = 0;

    logic [GW-1:0] m_secret;
    int            m_turn;
    int            m_state;
    logic [GW-1:0] m_hg[$];
    int            m_he[$];
    int            m_hp[$];

    mastermind_engine #(.PEGS(PEGS), .COLORS(COLORS), .MAX_TURNS(MAX_TURNS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .secret(secret),
        .guess_valid(guess_valid), .guess_ready(guess_ready), .guess(guess),
        .score_valid(score_valid), .exact(exact), .partial(partial),
        .bad_guess(bad_guess), .turn(turn), .state(state), .hist_idx(hist_idx),
        .hist_guess(hist_guess), .hist_exact(hist_exact), .hist_partial(hist_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int peg(input logic [GW-1:0] c, input int i);
        return int'((c >> (3 * i)) & 12'h007);
    endfunction

    function automatic logic [GW-1:0] code(input int a, input int b, input int c, input int d);
        return GW'(a) | (GW'(b) << 3) | (GW'(c) << 6) | (GW'(d) << 9);
    endfunction

    function automatic logic [GW-1:0] rand_code();
        logic [GW-1:0] c;
        c = 12'h000;
        for (int i = 0; i < PEGS; i++) c = c | (GW'($urandom_range(COLORS - 1, 0)) << (3 * i));
        return c;
    endfunction

    function automatic logic [GW-1:0] wrong_code(input logic [GW-1:0] s);
        logic [GW-1:0] c;
        c = rand_code();
        if (c == s) c = (c & 12'hFF8) | GW'((peg(c, 0) + 1) % COLORS);
        return c;
    endfunction

    // Mastermind rules: exact by position; total common = sum over colours of min counts
    function automatic void score_model(input logic [GW-1:0] s, input logic [GW-1:0] g,
                                        output int ex, output int pa);
        int cs[8];
        int cg[8];
        int tot;
        ex = 0;
        tot = 0;
        for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
        for (int i = 0; i < PEGS; i++) begin
            if (peg(s, i) == peg(g, i)) ex++;
            cs[peg(s, i)]++;
            cg[peg(g, i)]++;
        end
        for (int c = 0; c < COLORS; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
        pa = tot - ex;
    endfunction

    function automatic void model_start(input logic [GW-1:0] s);
        m_secret = s;
        m_turn = 0;
        m_state = 1;
        m_hg.delete();
        m_he.delete();
        m_hp.delete();
    endfunction

    function automatic void model_guess(input logic [GW-1:0] g, output int ex, output int pa);
        score_model(m_secret, g, ex, pa);
        m_hg.push_back(g);
        m_he.push_back(ex);
        m_hp.push_back(pa);
        m_turn++;
        if (ex == PEGS) m_state = 2;
        else if (m_turn == MAX_TURNS) m_state = 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [GW-1:0] s);
        secret = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one guess for one edge, then wait (bounded) for score_valid; lat = -1 on timeout
    task automatic submit(input logic [GW-1:0] g, output int lat);
        guess = g;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (score_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        guess_valid = 1'b0;
        secret = 12'h000;
        guess = 12'h000;
        hist_idx = 4'd0;
        #22;
        checks++;
        if ({state, turn, exact, partial} !== 12'h000) begin
            errors++;
            $display("FAIL reset_regs state=%0d turn=%0d exact=%0d partial=%0d want all 0", state, turn, exact, partial);
        end
        checks++;
        if ({guess_ready, score_valid, bad_guess} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags ready/sv/bad=%b want 000", {guess_ready, score_valid, bad_guess});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({hist_guess, hist_exact, hist_partial} !== 18'h0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_hist hist=%h state=%0d want 0 and IDLE", {hist_guess, hist_exact, hist_partial}, state);
        end
    endtask

    task automatic test_basic();
        int ex, pa, lat;
        logic [GW-1:0] g;
        pulse_start(code(1, 2, 3, 4));
        model_start(code(1, 2, 3, 4));
        checks++;
        if (state !== 2'd1 || guess_ready !== 1'b1 || turn !== 4'd0) begin
            errors++;
            $display("FAIL basic_play state=%0d ready=%b turn=%0d want 1 1 0", state, guess_ready, turn);
        end
        g = code(4, 3, 2, 1);
        model_guess(g, ex, pa);
        guess = g;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        checks++;
        if (guess_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_drop ready=%b want 0", guess_ready);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (score_valid === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (exact !== 3'd0 || partial !== 3'd4 || exact !== PW'(ex) || partial !== PW'(pa) || turn !== 4'd1) begin
            errors++;
            $display("FAIL basic_score exact=%0d partial=%0d turn=%0d want 0 4 1", exact, partial, turn);
        end
        tick();
        checks++;
        if (score_valid !== 1'b0 || partial !== 3'd4 || guess_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold sv=%b partial=%0d ready=%b want 0 4 1", score_valid, partial, guess_ready);
        end
    endtask

    task automatic test_history();
        int ex, pa, lat;
        logic [GW-1:0] g;
        pulse_start(code(1, 1, 2, 2));
        model_start(code(1, 1, 2, 2));
        hist_idx = 4'd0;
        g = code(1, 2, 1, 1);
        model_guess(g, ex, pa);
        submit(g, lat);
        checks++;
        if (lat != LAT || exact !== 3'd1 || partial !== 3'd2 || exact !== PW'(ex) || partial !== PW'(pa)) begin
            errors++;
            $display("FAIL hist_score lat=%0d exact=%0d partial=%0d want %0d 1 2", lat, exact, partial, LAT);
        end
        checks++;
        if ({hist_guess, hist_exact, hist_partial} !== {g, PW'(ex), PW'(pa)}) begin
            errors++;
            $display("FAIL hist_write_first got %h/%0d/%0d want %h/%0d/%0d", hist_guess, hist_exact, hist_partial, g, ex, pa);
        end
        tick();
        checks++;
        if ({hist_guess, hist_exact, hist_partial} !== {g, PW'(ex), PW'(pa)}) begin
            errors++;
            $display("FAIL hist_read0 got %h/%0d/%0d want %h/%0d/%0d", hist_guess, hist_exact, hist_partial, g, ex, pa);
        end
        hist_idx = 4'd1;
        tick();
        checks++;
        if ({hist_guess, hist_exact, hist_partial} !== 18'h0) begin
            errors++;
            $display("FAIL hist_unwritten got %h want 0", {hist_guess, hist_exact, hist_partial});
        end
    endtask

    task automatic test_win();
        int ex, pa, lat, seen;
        pulse_start(code(5, 0, 5, 0));
        model_start(code(5, 0, 5, 0));
        model_guess(code(5, 0, 5, 0), ex, pa);
        submit(code(5, 0, 5, 0), lat);
        checks++;
        if (lat != LAT || exact !== 3'd4 || state !== 2'd2 || guess_ready !== 1'b0 || turn !== 4'd1 || m_state != 2) begin
            errors++;
            $display("FAIL win_first lat=%0d exact=%0d state=%0d ready=%b turn=%0d want %0d 4 2 0 1", lat, exact, state, guess_ready, turn, LAT);
        end
        seen = 0;
        guess = code(1, 1, 1, 1);
        guess_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (score_valid === 1'b1 || bad_guess === 1'b1) seen++;
        end
        guess_valid = 1'b0;
        checks++;
        if (seen != 0 || turn !== 4'd1 || state !== 2'd2) begin
            errors++;
            $display("FAIL win_ignore pulses=%0d turn=%0d state=%0d want 0 1 2", seen, turn, state);
        end
    endtask

    task automatic test_turn_limit(input bool_win);
        int ex, pa, lat, bad;
        logic [GW-1:0] s, g;
        s = rand_code();
        pulse_start(s);
        model_start(s);
        bad = 0;
        for (int t = 0; t < MAX_TURNS; t++) begin
            g = (bool_win && t == MAX_TURNS - 1) ? s : wrong_code(s);
            model_guess(g, ex, pa);
            submit(g, lat);
            checks++;
            if (lat != LAT || exact !== PW'(ex) || partial !== PW'(pa) || turn !== TW'(m_turn) || state !== 2'(m_state)) begin
                errors++;
                $display("FAIL limit_turn%0d lat=%0d e/p=%0d/%0d turn=%0d state=%0d want %0d/%0d %0d %0d",
                         t, lat, exact, partial, turn, state, ex, pa, m_turn, m_state);
            end
        end
        checks++;
        if (state !== (bool_win ? 2'd2 : 2'd3) || turn !== 4'd10 || guess_ready !== 1'b0) begin
            errors++;
            $display("FAIL limit_end win=%0d state=%0d turn=%0d ready=%b", bool_win, state, turn, guess_ready);
        end
    endtask

    task automatic test_random_games();
        int ex, pa, lat, guard;
        logic [GW-1:0] s, g, eg;
        int ee, ep;
        for (int game = 0; game < 4; game++) begin
            s = rand_code();
            pulse_start(s);
            model_start(s);
            guard = 0;
            while (m_state == 1 && guard < MAX_TURNS + 1) begin
                guard++;
                g = ($urandom_range(5, 0) == 0) ? s : rand_code();
                model_guess(g, ex, pa);
                submit(g, lat);
                checks++;
                if (lat != LAT || exact !== PW'(ex) || partial !== PW'(pa) || turn !== TW'(m_turn) || state !== 2'(m_state)) begin
                    errors++;
                    $display("FAIL rand_g%0d_t%0d g=%h lat=%0d e/p=%0d/%0d turn=%0d state=%0d want %0d/%0d %0d %0d",
                             game, m_turn, g, lat, exact, partial, turn, state, ex, pa, m_turn, m_state);
                end
            end
            for (int i = 0; i < 16; i++) begin
                hist_idx = TW'(i);
                tick();
                eg = (i < m_turn) ? m_hg[i] : 12'h000;
                ee = (i < m_turn) ? m_he[i] : 0;
                ep = (i < m_turn) ? m_hp[i] : 0;
                checks++;
                if ({hist_guess, hist_exact, hist_partial} !== {eg, PW'(ee), PW'(ep)}) begin
                    errors++;
                    $display("FAIL rand_hist g%0d idx%0d got %h/%0d/%0d want %h/%0d/%0d",
                             game, i, hist_guess, hist_exact, hist_partial, eg, ee, ep);
                end
            end
        end
    endtask

    task automatic test_bad_guess();
        int seen;
        pulse_start(rand_code());
        guess = code(1, 7, 0, 0);
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        checks++;
        if (bad_guess !== 1'b1 || turn !== 4'd0 || state !== 2'd1 || guess_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_pulse bad=%b turn=%0d state=%0d ready=%b want 1 0 1 1", bad_guess, turn, state, guess_ready);
        end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (score_valid === 1'b1 || bad_guess === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || turn !== 4'd0 || hist_guess !== 12'h000) begin
            errors++;
            $display("FAIL bad_after pulses=%0d turn=%0d want 0 0", seen, turn);
        end
    endtask

    task automatic test_abort();
        int ex, pa, lat, seen;
        logic [GW-1:0] s2, g;
        pulse_start(code(1, 2, 3, 4));
        guess = code(1, 2, 3, 4);
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick();
        tick();
        tick();
        s2 = rand_code();
        pulse_start(s2);
        model_start(s2);
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (score_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || turn !== 4'd0 || state !== 2'd1 || exact !== 3'd0 || partial !== 3'd0 || guess_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort pulses=%0d turn=%0d state=%0d e/p=%0d/%0d ready=%b", seen, turn, state, exact, partial, guess_ready);
        end
        g = wrong_code(s2);
        model_guess(g, ex, pa);
        submit(g, lat);
        checks++;
        if (lat != LAT || exact !== PW'(ex) || partial !== PW'(pa) || turn !== 4'd1) begin
            errors++;
            $display("FAIL abort_next lat=%0d e/p=%0d/%0d turn=%0d want %0d/%0d 1", lat, exact, partial, turn, ex, pa);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(code(2, 2, 3, 3));
        guess = code(3, 3, 2, 2);
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, turn, exact, partial, guess_ready, score_valid, bad_guess} !== 15'h0) begin
            errors++;
            $display("FAIL reset_mid state=%0d turn=%0d e/p=%0d/%0d ready=%b", state, turn, exact, partial, guess_ready);
        end
        #2;
        rst_n = 1'b1;
        hist_idx = 4'd0;
        tick();
        checks++;
        if ({hist_guess, hist_exact, hist_partial} !== 18'h0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_hist hist=%h state=%0d want 0 0", {hist_guess, hist_exact, hist_partial}, state);
        end
    endtask

    task automatic test_bad_secret();
        int ex, pa, lat;
        logic [GW-1:0] s, g;
        pulse_start(code(6, 0, 0, 0));
        checks++;
        if (state !== 2'd0 || guess_ready !== 1'b0) begin
            errors++;
            $display("FAIL badsec_idle state=%0d ready=%b want 0 0", state, guess_ready);
        end
        s = rand_code();
        pulse_start(s);
        model_start(s);
        g = wrong_code(s);
        model_guess(g, ex, pa);
        submit(g, lat);
        pulse_start(code(0, 0, 7, 0));
        checks++;
        if (state !== 2'd1 || turn !== 4'd1) begin
            errors++;
            $display("FAIL badsec_play state=%0d turn=%0d want 1 1", state, turn);
        end
        g = wrong_code(s);
        model_guess(g, ex, pa);
        submit(g, lat);
        checks++;
        if (lat != LAT || exact !== PW'(ex) || partial !== PW'(pa) || turn !== 4'd2) begin
            errors++;
            $display("FAIL badsec_keep lat=%0d e/p=%0d/%0d turn=%0d want %0d/%0d 2", lat, exact, partial, turn, ex, pa);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_history();
        test_win();
        test_turn_limit(1'b1);
        test_turn_limit(1'b0);
        test_random_games();
        test_bad_guess();
        test_abort();
        test_reset_mid();
        test_bad_secret();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
